// File: rtl/multicycle_control_if.sv
// Signal bundle between the Spartan multicycle sequencer and its datapath/memories.
// With MEM_WAIT_EN defined the bundle also carries the memory handshake mem_ready.
interface multicycle_control_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] i_bus;
  logic [DATA_W-1:0] flags;
  wire  [DATA_W-1:0] d_bus;
  logic              mem_read;
  logic              mem_write;
`ifdef MEM_WAIT_EN
  logic              mem_ready;
`endif
  logic              pc_increment;
  logic              pc_load;
  logic              cmp_load;
  logic              cmp_compare;
  logic [3:0]        lu_op;
  logic              reg1_read;
  logic              reg2_read;
  logic              reg3_write;
  logic [3:0]        reg1_addr;
  logic [3:0]        reg2_addr;
  logic [3:0]        reg3_addr;
  logic              halted;

  modport master (
`ifdef MEM_WAIT_EN
    input  mem_ready,
`endif
    input  i_bus, flags,
    output d_bus, mem_read, mem_write, pc_increment, pc_load, cmp_load, cmp_compare,
    output lu_op, reg1_read, reg2_read, reg3_write, reg1_addr, reg2_addr, reg3_addr, halted
  );

  modport slave (
`ifdef MEM_WAIT_EN
    output mem_ready,
`endif
    output i_bus, flags,
    input  d_bus, mem_read, mem_write, pc_increment, pc_load, cmp_load, cmp_compare,
    input  lu_op, reg1_read, reg2_read, reg3_write, reg1_addr, reg2_addr, reg3_addr, halted
  );
endinterface

// File: rtl/multicycle_control.sv
// Spartan CPU multicycle sequencer: FETCH/DECODE/EXEC/WB/HALT, Moore strobes from registered state.
// Optional MEM_WAIT_EN adds mem_ready wait states on FETCH, ldm EXEC and stm WB.
module multicycle_control #(
  parameter int DATA_W          = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_ALU3, OP_CMP, OP_JMP, OP_UNARY, OP_LDM, OP_STM, OP_LDL, OP_GTF, OP_STF, OP_ILL
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] lu_op;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] r3;
  } dec_t;

  state_e     state, state_n;
  logic [15:0] instr;
  op_e        op_q;
  logic       jmp_take;
  logic       drive_ibus, drive_flags;
  logic       fetch_done, exec_done, wb_done;
  dec_t       dec;

`ifdef MEM_WAIT_EN
  assign fetch_done = bus.mem_ready;
  assign exec_done  = (op_q != OP_LDM) || bus.mem_ready;
  assign wb_done    = (op_q != OP_STM) || bus.mem_ready;
`else
  assign fetch_done = 1'b1;
  assign exec_done  = 1'b1;
  assign wb_done    = 1'b1;
`endif

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dec = '{op: OP_ILL, lu_op: 4'd0, r1: 4'd0, r2: 4'd0, r3: 4'd0};
    if (instr == 16'hFFFF) begin
      dec.op = OP_NOP;
    end else if (instr[15:12] inside {[4'd1:4'd7]}) begin
      dec = '{op: OP_ALU3, lu_op: instr[15:12], r1: instr[11:8], r2: instr[7:4], r3: instr[3:0]};
    end else if (instr[15:8] == 8'hFF) begin
      case (instr[7:4])
        4'd1:    begin dec.op = OP_LDL; dec.r3 = instr[3:0]; end
        4'd2:    begin dec.op = OP_GTF; dec.r3 = instr[3:0]; end
        4'd3:    begin dec.op = OP_STF; dec.r1 = instr[3:0]; end
        default: ;
      endcase
    end else if (instr[15:12] == 4'hF) begin
      case (instr[11:8])
        4'd1:    begin dec.op = OP_CMP; dec.r1 = instr[7:4]; dec.r2 = instr[3:0]; end
        4'd2:    begin dec.op = OP_JMP; dec.r1 = instr[3:0]; end
        4'd3:    dec = '{op: OP_UNARY, lu_op: 4'd8, r1: instr[7:4], r2: 4'd0, r3: instr[3:0]};
        4'd4:    dec = '{op: OP_UNARY, lu_op: 4'd0, r1: instr[7:4], r2: 4'd0, r3: instr[3:0]};
        4'd6:    begin dec.op = OP_LDM; dec.r1 = instr[7:4]; dec.r3 = instr[3:0]; end
        4'd7:    begin dec.op = OP_STM; dec.r1 = instr[7:4]; dec.r2 = instr[3:0]; end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr         <= 16'h0000;
      op_q          <= OP_NOP;
      jmp_take      <= 1'b0;
      bus.lu_op     <= 4'd0;
      bus.reg1_addr <= 4'd0;
      bus.reg2_addr <= 4'd0;
      bus.reg3_addr <= 4'd0;
    end else begin
      if (state == S_FETCH && fetch_done) instr <= bus.i_bus[15:0];
      if (state == S_DECODE) begin
        op_q          <= dec.op;
        bus.lu_op     <= dec.lu_op;
        bus.reg1_addr <= dec.r1;
        bus.reg2_addr <= dec.r2;
        bus.reg3_addr <= dec.r3;
      end
      // Condition code F means unconditional; the flag is sampled once, at the end of EXEC.
      if (state == S_EXEC) jmp_take <= (instr[7:4] == 4'hF) || bus.flags[instr[7:4]];
    end
  end

  always_comb begin
    state_n          = state;
    bus.pc_increment = 1'b0;
    bus.pc_load      = 1'b0;
    bus.cmp_load     = 1'b0;
    bus.cmp_compare  = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.reg1_read    = 1'b0;
    bus.reg2_read    = 1'b0;
    bus.reg3_write   = 1'b0;
    bus.halted       = 1'b0;
    drive_ibus       = 1'b0;
    drive_flags      = 1'b0;
    case (state)
      S_FETCH: begin
        // Reset parks the FSM in FETCH; the rst term keeps the PC still while reset is held.
        bus.pc_increment = fetch_done && !rst;
        if (fetch_done) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (dec.op == OP_NOP)      state_n = S_FETCH;
        else if (dec.op == OP_ILL) state_n = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        else                       state_n = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_ALU3, OP_STM:          begin bus.reg1_read = 1'b1; bus.reg2_read = 1'b1; end
          OP_CMP:                   begin bus.reg1_read = 1'b1; bus.reg2_read = 1'b1;
                                          bus.cmp_compare = 1'b1; end
          OP_JMP, OP_UNARY, OP_STF: bus.reg1_read = 1'b1;
          OP_LDM:                   begin bus.reg1_read = 1'b1; bus.mem_read = 1'b1; end
          OP_LDL:                   drive_ibus = 1'b1;
          OP_GTF:                   drive_flags = 1'b1;
          default: ;
        endcase
        if (exec_done) state_n = S_WB;
      end
      S_WB: begin
        case (op_q)
          OP_ALU3:  begin bus.reg1_read = 1'b1; bus.reg2_read = 1'b1; bus.reg3_write = 1'b1; end
          OP_JMP:   begin bus.reg1_read = 1'b1; bus.pc_load = jmp_take; end
          OP_UNARY: begin bus.reg1_read = 1'b1; bus.reg3_write = 1'b1; end
          OP_LDM:   begin bus.reg1_read = 1'b1; bus.mem_read = 1'b1; bus.reg3_write = 1'b1; end
          OP_STM:   begin bus.reg1_read = 1'b1; bus.reg2_read = 1'b1; bus.mem_write = 1'b1; end
          OP_LDL:   begin drive_ibus = 1'b1; bus.reg3_write = 1'b1; bus.pc_increment = 1'b1; end
          OP_GTF:   begin drive_flags = 1'b1; bus.reg3_write = 1'b1; end
          OP_STF:   begin bus.reg1_read = 1'b1; bus.cmp_load = 1'b1; end
          default: ;
        endcase
        if (wb_done) state_n = S_FETCH;
      end
      S_HALT:  bus.halted = 1'b1;
      default: state_n = S_FETCH;
    endcase
  end

  assign bus.d_bus = drive_ibus  ? bus.i_bus :
                     drive_flags ? bus.flags : {DATA_W{1'bz}};

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one halting DUT and one NOP-on-illegal DUT on shared stimulus.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  multicycle_control_if #(.DATA_W(16)) bus_h ();
  multicycle_control_if #(.DATA_W(16)) bus_n ();

  multicycle_control #(.DATA_W(16), .HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk (clk),
    .rst (rst),
    .bus (bus_h.master)
  );

  multicycle_control #(.DATA_W(16), .HALT_ON_ILLEGAL(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // An undriven d_bus reads as 'z in a four-state simulator and as zero in a two-state one.
  function automatic logic [15:0] dbus_idle(input logic [15:0] v);
    return {15'd0, (v === 16'hzzzz) || (v === 16'h0000)};
  endfunction

  task automatic drive(input logic [15:0] ibus, input logic [15:0] flg);
    bus_h.i_bus = ibus;
    bus_n.i_bus = ibus;
    bus_h.flags = flg;
    bus_n.flags = flg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(16'h1123, 16'h0000);
`ifdef MEM_WAIT_EN
    bus_h.mem_ready = 1'b1;
    bus_n.mem_ready = 1'b1;
`endif
    tick();
    tick();
    check("rst_pc_inc",  {15'd0, bus_h.pc_increment}, 16'd0);
    check("rst_w3",      {15'd0, bus_h.reg3_write},   16'd0);
    check("rst_halted",  {15'd0, bus_h.halted},       16'd0);
    check("rst_lu_op",   {12'd0, bus_h.lu_op},        16'd0);
    check("rst_r1_addr", {12'd0, bus_h.reg1_addr},    16'd0);
    check("rst_dbus",    dbus_idle(bus_h.d_bus),      16'd1);

    // add r3 = r1 + r2
    rst = 1'b0;
    #1;
    check("add_fetch_pc", {15'd0, bus_h.pc_increment}, 16'd1);
    tick();
    check("add_dec_pc",   {15'd0, bus_h.pc_increment}, 16'd0);
    check("add_dec_r1",   {15'd0, bus_h.reg1_read},    16'd0);
    tick();
    check("add_ex_r1",    {15'd0, bus_h.reg1_read},    16'd1);
    check("add_ex_r2",    {15'd0, bus_h.reg2_read},    16'd1);
    check("add_ex_a1",    {12'd0, bus_h.reg1_addr},    16'd1);
    check("add_ex_a2",    {12'd0, bus_h.reg2_addr},    16'd2);
    check("add_ex_lu",    {12'd0, bus_h.lu_op},        16'd1);
    check("add_ex_w3",    {15'd0, bus_h.reg3_write},   16'd0);
    tick();
    check("add_wb_w3",    {15'd0, bus_h.reg3_write},   16'd1);
    check("add_wb_a3",    {12'd0, bus_h.reg3_addr},    16'd3);
    check("add_wb_lu",    {12'd0, bus_h.lu_op},        16'd1);
    tick();
    check("add_next_pc",  {15'd0, bus_h.pc_increment}, 16'd1);
    check("add_next_w3",  {15'd0, bus_h.reg3_write},   16'd0);

    // reset pulse in the WB cycle of an add
    tick();
    tick();
    tick();
    check("rwb_w3_pre",   {15'd0, bus_h.reg3_write},   16'd1);
    rst = 1'b1;
    #1;
    check("rwb_w3",       {15'd0, bus_h.reg3_write},   16'd0);
    check("rwb_r1",       {15'd0, bus_h.reg1_read},    16'd0);
    check("rwb_pc",       {15'd0, bus_h.pc_increment}, 16'd0);
    check("rwb_lu",       {12'd0, bus_h.lu_op},        16'd0);
    check("rwb_a3",       {12'd0, bus_h.reg3_addr},    16'd0);
    check("rwb_dbus",     dbus_idle(bus_h.d_bus),      16'd1);
    tick();
    check("rwb_w3_hold",  {15'd0, bus_h.reg3_write},   16'd0);
    rst = 1'b0;
    #1;
    check("rwb_fetch_pc", {15'd0, bus_h.pc_increment}, 16'd1);

    // ldl r5 with literal 00AB
    drive(16'hFF15, 16'h0000);
    tick();
    drive(16'h00AB, 16'h0000);
    tick();
    check("ldl_ex_dbus",  bus_h.d_bus,                 16'h00AB);
    check("ldl_ex_w3",    {15'd0, bus_h.reg3_write},   16'd0);
    check("ldl_ex_pc",    {15'd0, bus_h.pc_increment}, 16'd0);
    tick();
    check("ldl_wb_dbus",  bus_h.d_bus,                 16'h00AB);
    check("ldl_wb_w3",    {15'd0, bus_h.reg3_write},   16'd1);
    check("ldl_wb_a3",    {12'd0, bus_h.reg3_addr},    16'd5);
    check("ldl_wb_pc",    {15'd0, bus_h.pc_increment}, 16'd1);
    tick();
    check("ldl_f_dbus",   dbus_idle(bus_h.d_bus),      16'd1);

    // gtf r7
    drive(16'hFF27, 16'h5A5A);
    tick();
    tick();
    check("gtf_ex_dbus",  bus_h.d_bus,                 16'h5A5A);
    tick();
    check("gtf_wb_w3",    {15'd0, bus_h.reg3_write},   16'd1);
    check("gtf_wb_a3",    {12'd0, bus_h.reg3_addr},    16'd7);
    tick();

    // jmp cond 3 via r4, flag clear
    drive(16'hF234, 16'h0000);
    tick();
    tick();
    check("jmp0_ex_r1",   {15'd0, bus_h.reg1_read},    16'd1);
    check("jmp0_ex_a1",   {12'd0, bus_h.reg1_addr},    16'd4);
    check("jmp0_ex_ld",   {15'd0, bus_h.pc_load},      16'd0);
    tick();
    check("jmp0_wb_ld",   {15'd0, bus_h.pc_load},      16'd0);
    tick();

    // jmp cond 3, flag set
    drive(16'hF234, 16'h0008);
    tick();
    tick();
    tick();
    check("jmp1_wb_ld",   {15'd0, bus_h.pc_load},      16'd1);
    tick();
    check("jmp1_f_ld",    {15'd0, bus_h.pc_load},      16'd0);

    // jmp cond F is unconditional
    drive(16'hF2F4, 16'h0000);
    tick();
    tick();
    tick();
    check("jmpF_wb_ld",   {15'd0, bus_h.pc_load},      16'd1);
    tick();

    // cmp r1, r2
    drive(16'hF112, 16'h0000);
    tick();
    tick();
    check("cmp_ex_cmp",   {15'd0, bus_h.cmp_compare},  16'd1);
    check("cmp_ex_a1",    {12'd0, bus_h.reg1_addr},    16'd1);
    check("cmp_ex_a2",    {12'd0, bus_h.reg2_addr},    16'd2);
    tick();
    check("cmp_wb_cmp",   {15'd0, bus_h.cmp_compare},  16'd0);
    tick();

    // ldm r2 <- mem[r1]
    drive(16'hF612, 16'h0000);
    tick();
    tick();
    check("ldm_ex_mr",    {15'd0, bus_h.mem_read},     16'd1);
    check("ldm_ex_a1",    {12'd0, bus_h.reg1_addr},    16'd1);
    tick();
    check("ldm_wb_mr",    {15'd0, bus_h.mem_read},     16'd1);
    check("ldm_wb_w3",    {15'd0, bus_h.reg3_write},   16'd1);
    check("ldm_wb_a3",    {12'd0, bus_h.reg3_addr},    16'd2);
    tick();

    // stm mem[r3] <- r4
    drive(16'hF734, 16'h0000);
    tick();
    tick();
    check("stm_ex_mw",    {15'd0, bus_h.mem_write},    16'd0);
    tick();
    check("stm_wb_mw",    {15'd0, bus_h.mem_write},    16'd1);
    check("stm_wb_a1",    {12'd0, bus_h.reg1_addr},    16'd3);
    check("stm_wb_a2",    {12'd0, bus_h.reg2_addr},    16'd4);
    tick();

    // neg r6 <- ~r5
    drive(16'hF356, 16'h0000);
    tick();
    tick();
    check("neg_ex_lu",    {12'd0, bus_h.lu_op},        16'd8);
    check("neg_ex_a1",    {12'd0, bus_h.reg1_addr},    16'd5);
    tick();
    check("neg_wb_w3",    {15'd0, bus_h.reg3_write},   16'd1);
    check("neg_wb_a3",    {12'd0, bus_h.reg3_addr},    16'd6);
    tick();

    // stf r9
    drive(16'hFF39, 16'h0000);
    tick();
    tick();
    check("stf_ex_cl",    {15'd0, bus_h.cmp_load},     16'd0);
    tick();
    check("stf_wb_cl",    {15'd0, bus_h.cmp_load},     16'd1);
    check("stf_wb_a1",    {12'd0, bus_h.reg1_addr},    16'd9);
    tick();

    // NOP returns to FETCH after DECODE
    drive(16'hFFFF, 16'h0000);
    tick();
    check("nop_dec_pc",   {15'd0, bus_h.pc_increment}, 16'd0);
    tick();
    check("nop_fetch_pc", {15'd0, bus_h.pc_increment}, 16'd1);

`ifdef MEM_WAIT_EN
    // ldm with mem_ready low for three EXEC cycles
    drive(16'hF612, 16'h0000);
    tick();
    bus_h.mem_ready = 1'b0;
    bus_n.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("ldmw_ex_mr", {15'd0, bus_h.mem_read},   16'd1);
      check("ldmw_ex_w3", {15'd0, bus_h.reg3_write}, 16'd0);
      tick();
    end
    bus_h.mem_ready = 1'b1;
    bus_n.mem_ready = 1'b1;
    #1;
    check("ldmw_ex4_mr",  {15'd0, bus_h.mem_read},     16'd1);
    tick();
    check("ldmw_wb_w3",   {15'd0, bus_h.reg3_write},   16'd1);
    tick();
`endif

    // illegal opcode: one DUT halts, the other treats it as NOP
    drive(16'h9000, 16'h0000);
    tick();
    tick();
    check("ill_h_halted", {15'd0, bus_h.halted},       16'd1);
    check("ill_h_pc",     {15'd0, bus_h.pc_increment}, 16'd0);
    check("ill_n_halted", {15'd0, bus_n.halted},       16'd0);
    check("ill_n_pc",     {15'd0, bus_n.pc_increment}, 16'd1);
    for (int i = 0; i < 5; i++) tick();
    check("ill_h_stuck",  {15'd0, bus_h.halted},       16'd1);
    check("ill_h_pc2",    {15'd0, bus_h.pc_increment}, 16'd0);
    check("ill_h_dbus",   dbus_idle(bus_h.d_bus),      16'd1);
    rst = 1'b1;
    #1;
    check("ill_rst_halt", {15'd0, bus_h.halted},       16'd0);
    tick();
    rst = 1'b0;
    #1;
    check("ill_rel_pc",   {15'd0, bus_h.pc_increment}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
